// File: rtl/icache_pkg.sv
// Shared types and sizing helpers for the instruction-cache set with streamed refill.
package icache_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        FILL   = 3'b010,
        COMMIT = 3'b100
    } icache_fill_state_t;

    function automatic int beats_f(input int b, input int fill_w);
        return (b * 8) / fill_w;
    endfunction

    // A single-beat line still needs a 1-bit counter so the ports stay legal.
    function automatic int cnt_w_f(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/icache_lru_ages.sv
// Age-based true-LRU state for one E-way set: access update and victim selection.
module icache_lru_ages #(
    parameter int E = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 hit_acc_i,
    input  logic [$clog2(E)-1:0] hit_way_i,
    input  logic                 commit_acc_i,
    input  logic [$clog2(E)-1:0] commit_way_i,
    input  logic [E-1:0]         valid_i,
    output logic [$clog2(E)-1:0] victim_o
);

    localparam int AW = $clog2(E);

    logic [AW-1:0] age_q [E];
    logic [AW-1:0] age_d [E];
    logic [AW-1:0] acc_way;
    logic          acc_en;
    logic          invalid_found;

    // A commit and a hit in the same cycle: the commit owns the update.
    always_comb begin
        acc_way = commit_acc_i ? commit_way_i : hit_way_i;
        acc_en  = commit_acc_i | hit_acc_i;
        for (int i = 0; i < E; i++) begin
            age_d[i] = age_q[i];
        end
        if (acc_en) begin
            for (int i = 0; i < E; i++) begin
                if (AW'(i) == acc_way) begin
                    age_d[i] = '0;
                end else if (age_q[i] < age_q[acc_way]) begin
                    age_d[i] = age_q[i] + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < E; i++) begin
                age_q[i] <= AW'(i);
            end
        end else begin
            for (int i = 0; i < E; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    always_comb begin
        victim_o      = '0;
        invalid_found = 1'b0;
        for (int i = E - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                victim_o      = AW'(i);
                invalid_found = 1'b1;
            end
        end
        if (!invalid_found) begin
            for (int i = 0; i < E; i++) begin
                if (age_q[i] == AW'(E - 1)) begin
                    victim_o = AW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/instr_cache_set_stream.sv
// One E-way instruction-cache set with beat-streamed L2 refill, hit-under-fill and invalidate.
// Optional saturating hit/miss counters are enabled by defining ICACHE_SET_PERF_EN.
module instr_cache_set_stream
    import icache_pkg::*;
#(
    parameter int B      = 64,
    parameter int TAG_W  = 20,
    parameter int E      = 4,
    parameter int FILL_W = 64
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 active_set_i,
    input  logic [$clog2(B)-1:0] block_i,
    input  logic [TAG_W-1:0]     tag_i,
    input  logic                 invalidate_i,
    input  logic                 fill_grant_i,
    input  logic                 fill_valid_i,
    input  logic [FILL_W-1:0]    fill_data_i,
    output logic                 fill_req_o,
    output logic                 fill_done_o,
    output logic                 hit_o,
    output logic                 miss_o,
    output logic                 busy_o,
    output logic [31:0]          data_o,
    output logic [31:0]          hit_count_o,
    output logic [31:0]          miss_count_o
);

    localparam int BEATS = beats_f(B, FILL_W);
    localparam int CNT_W = cnt_w_f(BEATS);
    localparam int OFF_W = $clog2(B);
    localparam int AW    = $clog2(E);

    icache_fill_state_t state_q, state_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [AW-1:0]      victim_q, victim_d;
    logic [TAG_W-1:0]   fill_tag_q, fill_tag_d;
    logic [E-1:0]       valid_q, valid_d;

    logic [B*8-1:0]     line_q [E];
    logic [TAG_W-1:0]   tag_q [E];

    logic [E-1:0]       match;
    logic [AW-1:0]      hit_way;
    logic [AW-1:0]      victim;
    logic [OFF_W-3:0]   word_sel;
    logic               beat_acc;
    logic               commit;
    logic               blk_lsb_unused;

    assign blk_lsb_unused = ^block_i[1:0];

    always_comb begin
        match   = '0;
        hit_way = '0;
        for (int i = 0; i < E; i++) begin
            match[i] = valid_q[i] && (tag_q[i] == tag_i);
        end
        for (int i = E - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_way = AW'(i);
            end
        end
        hit_o    = active_set_i & (|match);
        miss_o   = active_set_i & ~hit_o;
        word_sel = block_i[OFF_W-1:2];
        data_o   = hit_o ? line_q[hit_way][word_sel*32 +: 32] : 32'h0;
    end

    icache_lru_ages #(.E(E)) u_lru (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .hit_acc_i    (hit_o && (state_q != COMMIT)),
        .hit_way_i    (hit_way),
        .commit_acc_i (commit),
        .commit_way_i (victim_q),
        .valid_i      (valid_q),
        .victim_o     (victim)
    );

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        victim_d   = victim_q;
        fill_tag_d = fill_tag_q;
        valid_d    = valid_q;
        beat_acc   = 1'b0;
        commit     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (miss_o && !invalidate_i) begin
                    state_d          = FILL;
                    fill_tag_d       = tag_i;
                    victim_d         = victim;
                    valid_d[victim]  = 1'b0;
                    beat_cnt_d       = '0;
                end
            end
            FILL: begin
                if (!invalidate_i && fill_valid_i && fill_grant_i) begin
                    beat_acc = 1'b1;
                    if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
                        state_d    = COMMIT;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            COMMIT: begin
                if (!invalidate_i) begin
                    commit            = 1'b1;
                    valid_d[victim_q] = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Invalidate aborts any refill and wipes the set, whatever else happened.
        if (invalidate_i) begin
            valid_d    = '0;
            beat_cnt_d = '0;
            state_d    = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            victim_q   <= '0;
            fill_tag_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            victim_q   <= victim_d;
            fill_tag_q <= fill_tag_d;
            valid_q    <= valid_d;
        end
    end

    // Line and tag storage carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk_i) begin
        if (beat_acc) begin
            line_q[victim_q][beat_cnt_q*FILL_W +: FILL_W] <= fill_data_i;
        end
        if (commit) begin
            tag_q[victim_q] <= fill_tag_q;
        end
    end

    assign fill_req_o  = (state_q == FILL);
    assign fill_done_o = (state_q == COMMIT);
    assign busy_o      = (state_q != IDLE);

`ifdef ICACHE_SET_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Misses are counted per refill started, not per missing lookup cycle.
    always_comb begin
        hit_cnt_d  = hit_o ? sat_inc(hit_cnt_q) : hit_cnt_q;
        miss_cnt_d = ((state_q == IDLE) && (state_d == FILL)) ? sat_inc(miss_cnt_q) : miss_cnt_q;
        if (invalidate_i) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`else
    assign hit_count_o  = 32'h0;
    assign miss_count_o = 32'h0;
`endif

endmodule

// File: tb/tb_instr_cache_set_stream.sv
// Scoreboard bench for instr_cache_set_stream (B=64, E=4, FILL_W=128, four beats per line).
module tb_instr_cache_set_stream;

    localparam int B      = 64;
    localparam int TAG_W  = 20;
    localparam int E      = 4;
    localparam int FILL_W = 128;
    localparam int BEATS  = 4;

    localparam logic [19:0] TA = 20'h12345;
    localparam logic [19:0] TB = 20'h0BBBB;
    localparam logic [19:0] TC = 20'h0CCCC;
    localparam logic [19:0] TD = 20'h0DDDD;
    localparam logic [19:0] TE = 20'h0EEEE;
    localparam logic [19:0] TF = 20'h0F0F0;
    localparam logic [19:0] TG = 20'h01111;
    localparam logic [19:0] TH = 20'h02222;
    localparam logic [19:0] TI = 20'h03333;

    logic              clk_i = 1'b0;
    logic              reset_ni = 1'b0;
    logic              active_set_i = 1'b0;
    logic [5:0]        block_i = '0;
    logic [TAG_W-1:0]  tag_i = '0;
    logic              invalidate_i = 1'b0;
    logic              fill_grant_i = 1'b0;
    logic              fill_valid_i = 1'b0;
    logic [FILL_W-1:0] fill_data_i = '0;
    logic              fill_req_o, fill_done_o, hit_o, miss_o, busy_o;
    logic [31:0]       data_o, hit_count_o, miss_count_o;

    instr_cache_set_stream #(.B(B), .TAG_W(TAG_W), .E(E), .FILL_W(FILL_W)) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .active_set_i (active_set_i),
        .block_i      (block_i),
        .tag_i        (tag_i),
        .invalidate_i (invalidate_i),
        .fill_grant_i (fill_grant_i),
        .fill_valid_i (fill_valid_i),
        .fill_data_i  (fill_data_i),
        .fill_req_o   (fill_req_o),
        .fill_done_o  (fill_done_o),
        .hit_o        (hit_o),
        .miss_o       (miss_o),
        .busy_o       (busy_o),
        .data_o       (data_o),
        .hit_count_o  (hit_count_o),
        .miss_count_o (miss_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        hit;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [31:0] mkword(input logic [19:0] t, input int w);
        return {t[15:0], 8'hC0, 8'(w)};
    endfunction

    function automatic logic [FILL_W-1:0] mkbeat(input logic [19:0] t, input int k);
        logic [FILL_W-1:0] r;
        for (int j = 0; j < 4; j++) r[j*32 +: 32] = mkword(t, 4 * k + j);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) $display("FAIL %s: got %h required %h at cycle %0d", name, act, req, cyc);
        else n_pass++;
    endtask

    // Monitor: pops an expectation whenever the DUT reports a lookup or a commit.
    always @(negedge clk_i) begin
        if (reset_ni && (hit_o || miss_o)) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL lookup_unexpected: got hit=%0b miss=%0b with no lookup issued", hit_o, miss_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("lookup_hit", {31'b0, hit_o}, {31'b0, e.hit});
                chk("lookup_data", data_o, e.data);
            end
        end
        if (reset_ni && fill_done_o) begin
            if (done_q.size() == 0) begin
                n_chk++;
                $display("FAIL fill_done_unexpected: pulse at cycle %0d, none required", cyc);
            end else begin
                chk("fill_done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic lookup(input logic [19:0] t, input logic [5:0] blk, input logic eh, input logic [31:0] ed);
        exp_t e;
        e.hit  = eh;
        e.data = ed;
        exp_q.push_back(e);
        active_set_i = 1'b1;
        tag_i        = t;
        block_i      = blk;
        tick();
        active_set_i = 1'b0;
    endtask

    task automatic start_fill(input logic [19:0] t);
        lookup(t, 6'h00, 1'b0, 32'h0);
        chk("fill_req_rise", {31'b0, fill_req_o}, 32'd1);
        chk("busy_in_fill", {31'b0, busy_o}, 32'd1);
    endtask

    // Gap cycles offer only half of the handshake, carrying corrupt data that must be ignored.
    task automatic beat(input logic [19:0] t, input int k, input int gap);
        for (int g = 0; g < gap; g++) begin
            fill_valid_i = (g % 2 == 0);
            fill_grant_i = (g % 2 != 0);
            fill_data_i  = ~mkbeat(t, k);
            tick();
            chk("stall_no_commit", {30'b0, fill_req_o, fill_done_o}, 32'd2);
        end
        if (k == BEATS - 1) done_q.push_back(cyc + 1);
        fill_valid_i = 1'b1;
        fill_grant_i = 1'b1;
        fill_data_i  = mkbeat(t, k);
        tick();
        fill_valid_i = 1'b0;
        fill_grant_i = 1'b0;
        fill_data_i  = '0;
    endtask

    task automatic finish_fill();
        chk("done_pulse", {31'b0, fill_done_o}, 32'd1);
        tick();
        chk("idle_after_commit", {29'b0, busy_o, fill_req_o, fill_done_o}, 32'd0);
    endtask

    task automatic full_fill(input logic [19:0] t);
        start_fill(t);
        for (int k = 0; k < BEATS; k++) beat(t, k, 0);
        finish_fill();
    endtask

    task automatic chk_cnt(input int h, input int m);
`ifdef ICACHE_SET_PERF_EN
        chk("hit_count", hit_count_o, h);
        chk("miss_count", miss_count_o, m);
`else
        chk("hit_count", hit_count_o, 32'd0 & h);
        chk("miss_count", miss_count_o, 32'd0 & m);
`endif
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time %0t exceeded bound", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #12 reset_ni = 1'b1;
        tick();
        chk("rst_outputs", {27'b0, fill_req_o, fill_done_o, busy_o, hit_o, miss_o}, 32'd0);
        chk("rst_data", data_o, 32'd0);
        chk_cnt(0, 0);

        // Cold fill of tag A into way 0, then word 5 = bits [63:32] of beat 1.
        full_fill(TA);
        lookup(TA, 6'h14, 1'b1, 32'h2345_C005);

        // Stalled fill of B into way 1; block_i[1:0] ignored.
        start_fill(TB);
        beat(TB, 0, 2);
        beat(TB, 1, 3);
        beat(TB, 2, 1);
        beat(TB, 3, 4);
        finish_fill();
        lookup(TB, 6'h08, 1'b1, mkword(TB, 2));
        lookup(TB, 6'h3C, 1'b1, mkword(TB, 15));
        lookup(TB, 6'h17, 1'b1, mkword(TB, 5));

        // Fill C, D; touch A; miss E must evict way 1 (B, age 3).
        full_fill(TC);
        full_fill(TD);
        lookup(TA, 6'h00, 1'b1, mkword(TA, 0));
        full_fill(TE);
        lookup(TE, 6'h30, 1'b1, mkword(TE, 12));
        lookup(TA, 6'h24, 1'b1, mkword(TA, 9));

        // Fill F into way 2 (C) with hits under fill, and a hit coinciding with COMMIT.
        start_fill(TF);
        beat(TF, 0, 0);
        lookup(TD, 6'h04, 1'b1, mkword(TD, 1));
        lookup(TC, 6'h04, 1'b0, 32'h0);
        beat(TF, 1, 0);
        beat(TF, 2, 0);
        beat(TF, 3, 0);
        chk("done_pulse_hitcommit", {31'b0, fill_done_o}, 32'd1);
        lookup(TA, 6'h38, 1'b1, mkword(TA, 14));
        chk("idle_after_hitcommit", {31'b0, busy_o}, 32'd0);
        lookup(TF, 6'h20, 1'b1, mkword(TF, 8));

        // Commit won the LRU update, so G replaces way 1 (E) and F survives.
        full_fill(TG);
        lookup(TF, 6'h3C, 1'b1, mkword(TF, 15));
        lookup(TG, 6'h10, 1'b1, mkword(TG, 4));

        // E was evicted: its miss starts a fill that is invalidated after 2 beats.
        start_fill(TE);
        beat(TE, 0, 0);
        beat(TE, 1, 0);
        invalidate_i = 1'b1;
        tick();
        invalidate_i = 1'b0;
        chk("inval_to_idle", {30'b0, busy_o, fill_req_o}, 32'd0);
        chk_cnt(0, 0);
        tick();
        chk("inval_no_done", {31'b0, fill_done_o}, 32'd0);

        // Everything invalid now: F misses and starts a fill cut short by async reset.
        start_fill(TF);
        beat(TF, 0, 0);
        #2 reset_ni = 1'b0;
        #1;
        chk("async_rst_outputs", {29'b0, fill_req_o, fill_done_o, busy_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #3 reset_ni = 1'b1;
        tick();
        chk("post_rst_idle", {31'b0, busy_o}, 32'd0);
        chk_cnt(0, 0);

        // Two refills and five hits for the performance counters.
        full_fill(TH);
        full_fill(TI);
        lookup(TH, 6'h3C, 1'b1, mkword(TH, 15));
        lookup(TI, 6'h00, 1'b1, mkword(TI, 0));
        lookup(TH, 6'h18, 1'b1, mkword(TH, 6));
        lookup(TI, 6'h2C, 1'b1, mkword(TI, 11));
        lookup(TH, 6'h04, 1'b1, mkword(TH, 1));
        tick();
        chk_cnt(5, 2);

        repeat (2) tick();
        chk("lookups_drained", exp_q.size(), 32'd0);
        chk("dones_drained", done_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
